calc_key_sequencer: RTL and testbench

- Sits between the keypad decoder and the stack datapath of the stack calculator.
- Consumes one decoded 4-bit key token per new-token flag and builds multi-digit decimal operands.
- Issues PUSH / arithmetic / CLEAR commands to the stack over a valid/ready handshake.
- Drops keys that arrive while a command is pending and flags the drop.

---
 rtl/calc_key_sequencer.sv | 172 +++++++++++++++++
 tb/tb_calc_key_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_key_sequencer.sv
// Key sequencer for the stack calculator: turns decoded keypad tokens into
// multi-digit operands and PUSH / arithmetic / CLEAR commands over valid/ready.
module calc_key_sequencer #(
    parameter int WIDTH = 16,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_new,
    input  logic [3:0]       key_code,
    output logic             cmd_valid,
    output logic [OPW-1:0]   cmd_op,
    output logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_ready,
    output logic [WIDTH-1:0] entry_value,
    output logic             entry_active,
    output logic             overflow,
    output logic             key_dropped
);

    localparam logic [OPW-1:0] OP_PUSH = OPW'(0);
    localparam logic [OPW-1:0] OP_CLR  = OPW'(5);
    localparam int             XW      = WIDTH + 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_PUSH,
        S_OP,
        S_ACK_CLR
    } state_t;

    state_t           state_q;
    logic             kn_q;
    logic [WIDTH-1:0] entry_q;
    logic             active_q;
    logic             ovf_q;
    logic             pend_vld_q;
    logic [OPW-1:0]   pend_op_q;
    logic             cmd_valid_q;
    logic [OPW-1:0]   cmd_op_q;
    logic [WIDTH-1:0] cmd_data_q;
    logic             drop_q;

    logic             key_event;
    logic             xfer;
    logic             accepting;
    logic             is_digit;
    logic             is_arith;
    logic             is_enter;
    logic [XW-1:0]    digit_next;
    logic             digit_fits;
    logic [OPW-1:0]   arith_op;
    logic [3:0]       arith_idx;

    assign key_event  = key_new & ~kn_q;
    assign xfer       = cmd_valid_q & cmd_ready;
    assign accepting  = (state_q == S_IDLE) || (state_q == S_ENTRY);
    assign is_digit   = (key_code <= 4'd9);
    assign is_arith   = (key_code >= 4'hA) && (key_code <= 4'hD);
    assign is_enter   = (key_code == 4'hE);
    // Four extra bits hold entry*10+9 without wrapping, so the range test is exact.
    assign digit_next = {4'b0, entry_q} * XW'(10) + XW'(key_code);
    assign digit_fits = (digit_next <= {4'b0, {WIDTH{1'b1}}});
    assign arith_idx  = key_code - 4'd9;
    assign arith_op   = OPW'(arith_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            kn_q        <= 1'b0;
            entry_q     <= '0;
            active_q    <= 1'b0;
            ovf_q       <= 1'b0;
            pend_vld_q  <= 1'b0;
            pend_op_q   <= '0;
            cmd_valid_q <= 1'b0;
            cmd_op_q    <= '0;
            cmd_data_q  <= '0;
            drop_q      <= 1'b0;
        end else begin
            kn_q   <= key_new;
            // Busy states ignore keys; acceptance depends only on the current state.
            drop_q <= key_event & ~accepting;
            case (state_q)
                S_IDLE, S_ENTRY: begin
                    if (key_event) begin
                        if (is_digit) begin
                            if (digit_fits) begin
                                entry_q  <= digit_next[WIDTH-1:0];
                                active_q <= 1'b1;
                                state_q  <= S_ENTRY;
                            end else begin
                                ovf_q <= 1'b1;
                            end
                        end else if (is_arith) begin
                            if (state_q == S_ENTRY) begin
                                pend_vld_q  <= 1'b1;
                                pend_op_q   <= arith_op;
                                state_q     <= S_PUSH;
                                cmd_valid_q <= 1'b1;
                                cmd_op_q    <= OP_PUSH;
                                cmd_data_q  <= entry_q;
                            end else begin
                                state_q     <= S_OP;
                                cmd_valid_q <= 1'b1;
                                cmd_op_q    <= arith_op;
                                cmd_data_q  <= '0;
                            end
                        end else if (is_enter) begin
                            if (state_q == S_ENTRY) begin
                                state_q     <= S_PUSH;
                                cmd_valid_q <= 1'b1;
                                cmd_op_q    <= OP_PUSH;
                                cmd_data_q  <= entry_q;
                            end
                        end else begin
                            ovf_q <= 1'b0;
                            if (state_q == S_ENTRY) begin
                                entry_q  <= '0;
                                active_q <= 1'b0;
                                state_q  <= S_IDLE;
                            end else begin
                                state_q     <= S_ACK_CLR;
                                cmd_valid_q <= 1'b1;
                                cmd_op_q    <= OP_CLR;
                                cmd_data_q  <= '0;
                            end
                        end
                    end
                end
                S_PUSH: begin
                    if (xfer) begin
                        entry_q  <= '0;
                        active_q <= 1'b0;
                        ovf_q    <= 1'b0;
                        // A latched operator follows the push with no bubble.
                        if (pend_vld_q) begin
                            state_q    <= S_OP;
                            cmd_op_q   <= pend_op_q;
                            cmd_data_q <= '0;
                        end else begin
                            state_q     <= S_IDLE;
                            cmd_valid_q <= 1'b0;
                        end
                    end
                end
                S_OP, S_ACK_CLR: begin
                    if (xfer) begin
                        state_q     <= S_IDLE;
                        cmd_valid_q <= 1'b0;
                        pend_vld_q  <= 1'b0;
                        pend_op_q   <= '0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    cmd_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_valid    = cmd_valid_q;
    assign cmd_op       = cmd_op_q;
    assign cmd_data     = cmd_data_q;
    assign entry_value  = entry_q;
    assign entry_active = active_q;
    assign overflow     = ovf_q;
    assign key_dropped  = drop_q;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Directed bench for calc_key_sequencer: keys are driven on falling edges and
// command transfers are logged on rising edges.
module tb_calc_key_sequencer;

    logic        clk;
    logic        rst_n;
    logic        key_new;
    logic [3:0]  key_code;
    logic        cmd_valid;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_data;
    logic        cmd_ready;
    logic [15:0] entry_value;
    logic        entry_active;
    logic        overflow;
    logic        key_dropped;

    int total;
    int bad;
    int vcyc;
    int ncap;
    logic [2:0]  q_op[$];
    logic [15:0] q_data[$];

    calc_key_sequencer #(.WIDTH(16), .OPW(3)) dut (
        .clk(clk), .rst_n(rst_n), .key_new(key_new), .key_code(key_code),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .cmd_ready(cmd_ready), .entry_value(entry_value),
        .entry_active(entry_active), .overflow(overflow),
        .key_dropped(key_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cmd_valid === 1'b1) vcyc++;
        if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
            q_op.push_back(cmd_op);
            q_data.push_back(cmd_data);
        end
    end

    task automatic clr_log();
        q_op.delete();
        q_data.delete();
        vcyc = 0;
    endtask

    // One clean keystroke: high for one rising edge, then low for one to re-arm.
    task automatic press(input logic [3:0] k);
        key_code = k;
        key_new  = 1'b1;
        @(negedge clk);
        key_new  = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; key_new = 1'b0; key_code = 4'h0; cmd_ready = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({cmd_valid, cmd_op, cmd_data, entry_value, entry_active, overflow, key_dropped} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b op=%0d d=%0d e=%0d a=%b o=%b k=%b want all 0",
                     cmd_valid, cmd_op, cmd_data, entry_value, entry_active, overflow, key_dropped);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_digits_enter();
        logic [15:0] exp_e[3];
        exp_e[0] = 16'd1; exp_e[1] = 16'd12; exp_e[2] = 16'd123;
        cmd_ready = 1'b1;
        clr_log();
        for (int i = 0; i < 3; i++) begin
            press(4'(i + 1));
            total++;
            if (entry_value !== exp_e[i] || entry_active !== 1'b1) begin
                bad++;
                $display("FAIL digit_%0d: got e=%0d a=%b want e=%0d a=1", i, entry_value, entry_active, exp_e[i]);
            end
        end
        press(4'hE);
        repeat (2) @(negedge clk);
        total++;
        if (q_op.size() !== 1) begin
            bad++;
            $display("FAIL enter_count: got %0d transfers want 1", q_op.size());
        end else begin
            total++;
            if (q_op[0] !== 3'd0 || q_data[0] !== 16'd123) begin
                bad++;
                $display("FAIL enter_cmd: got op=%0d d=%0d want op=0 d=123", q_op[0], q_data[0]);
            end
        end
        total++;
        if (entry_active !== 1'b0 || entry_value !== 16'd0 || cmd_valid !== 1'b0) begin
            bad++;
            $display("FAIL enter_after: got a=%b e=%0d v=%b want 0 0 0", entry_active, entry_value, cmd_valid);
        end
    endtask

    task automatic test_back_to_back();
        cmd_ready = 1'b1;
        press(4'd7);
        clr_log();
        press(4'hA);
        repeat (2) @(negedge clk);
        total++;
        if (q_op.size() !== 2) begin
            bad++;
            $display("FAIL b2b_count: got %0d transfers want 2", q_op.size());
        end else begin
            total++;
            if (q_op[0] !== 3'd0 || q_data[0] !== 16'd7 || q_op[1] !== 3'd1 || q_data[1] !== 16'd0) begin
                bad++;
                $display("FAIL b2b_cmds: got {%0d,%0d} {%0d,%0d} want {0,7} {1,0}",
                         q_op[0], q_data[0], q_op[1], q_data[1]);
            end
        end
        total++;
        if (vcyc !== 2) begin
            bad++;
            $display("FAIL b2b_valid_cycles: got %0d want 2", vcyc);
        end
    endtask

    task automatic test_overflow();
        logic [3:0] ks[5];
        ks[0] = 4'd6; ks[1] = 4'd5; ks[2] = 4'd5; ks[3] = 4'd3; ks[4] = 4'd5;
        cmd_ready = 1'b1;
        clr_log();
        foreach (ks[i]) press(ks[i]);
        total++;
        if (entry_value !== 16'd65535 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL max_entry: got e=%0d o=%b want e=65535 o=0", entry_value, overflow);
        end
        press(4'd0);
        total++;
        if (entry_value !== 16'd65535 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL overflow_digit: got e=%0d o=%b want e=65535 o=1", entry_value, overflow);
        end
        press(4'hF);
        repeat (2) @(negedge clk);
        total++;
        if (entry_value !== 16'd0 || overflow !== 1'b0 || entry_active !== 1'b0 || q_op.size() !== 0) begin
            bad++;
            $display("FAIL entry_clear: got e=%0d o=%b a=%b n=%0d want 0 0 0 0",
                     entry_value, overflow, entry_active, q_op.size());
        end
    endtask

    task automatic test_stall_drop();
        int errs;
        cmd_ready = 1'b0;
        clr_log();
        press(4'd4);
        press(4'hE);
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            if (cmd_valid !== 1'b1 || cmd_op !== 3'd0 || cmd_data !== 16'd4) errs++;
            if (i == 4) begin
                key_code = 4'd9;
                key_new  = 1'b1;
            end
            @(negedge clk);
            if (i == 4) begin
                key_new = 1'b0;
                total++;
                if (key_dropped !== 1'b1 || entry_value !== 16'd4) begin
                    bad++;
                    $display("FAIL drop_pulse: got k=%b e=%0d want k=1 e=4", key_dropped, entry_value);
                end
            end
            if (i == 5) begin
                total++;
                if (key_dropped !== 1'b0) begin
                    bad++;
                    $display("FAIL drop_width: got k=%b want k=0", key_dropped);
                end
            end
        end
        total++;
        if (errs !== 0) begin
            bad++;
            $display("FAIL stall_hold: got %0d unstable cycles want 0", errs);
        end
        cmd_ready = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (q_op.size() !== 1 || cmd_valid !== 1'b0) begin
            bad++;
            $display("FAIL stall_release: got n=%0d v=%b want n=1 v=0", q_op.size(), cmd_valid);
        end else begin
            total++;
            if (q_op[0] !== 3'd0 || q_data[0] !== 16'd4) begin
                bad++;
                $display("FAIL stall_cmd: got op=%0d d=%0d want op=0 d=4", q_op[0], q_data[0]);
            end
        end
    endtask

    task automatic test_held_key();
        cmd_ready = 1'b1;
        clr_log();
        key_code = 4'd5;
        key_new  = 1'b1;
        repeat (50) @(negedge clk);
        key_new = 1'b0;
        @(negedge clk);
        total++;
        if (entry_value !== 16'd5) begin
            bad++;
            $display("FAIL held_key: got e=%0d want e=5", entry_value);
        end
        press(4'hF);
        press(4'hE);
        repeat (2) @(negedge clk);
        total++;
        if (q_op.size() !== 0 || entry_active !== 1'b0 || key_dropped !== 1'b0) begin
            bad++;
            $display("FAIL idle_enter: got n=%0d a=%b k=%b want 0 0 0", q_op.size(), entry_active, key_dropped);
        end
    endtask

    task automatic test_idle_clear();
        cmd_ready = 1'b1;
        clr_log();
        press(4'hF);
        repeat (2) @(negedge clk);
        total++;
        if (q_op.size() !== 1) begin
            bad++;
            $display("FAIL clr_count: got %0d transfers want 1", q_op.size());
        end else begin
            total++;
            if (q_op[0] !== 3'd5 || q_data[0] !== 16'd0) begin
                bad++;
                $display("FAIL clr_cmd: got op=%0d d=%0d want op=5 d=0", q_op[0], q_data[0]);
            end
        end
    endtask

    task automatic test_reset_mid_cmd();
        cmd_ready = 1'b0;
        clr_log();
        press(4'd8);
        press(4'hE);
        total++;
        if (cmd_valid !== 1'b1 || cmd_data !== 16'd8) begin
            bad++;
            $display("FAIL pre_reset_stall: got v=%b d=%0d want v=1 d=8", cmd_valid, cmd_data);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({cmd_valid, cmd_op, cmd_data, entry_value, entry_active, overflow, key_dropped} !== '0) begin
            bad++;
            $display("FAIL async_reset: got v=%b op=%0d d=%0d e=%0d a=%b want all 0",
                     cmd_valid, cmd_op, cmd_data, entry_value, entry_active);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cmd_ready = 1'b1;
        @(negedge clk);
        press(4'd3);
        total++;
        if (entry_value !== 16'd3 || entry_active !== 1'b1 || cmd_valid !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_digit: got e=%0d a=%b v=%b want e=3 a=1 v=0",
                     entry_value, entry_active, cmd_valid);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        vcyc  = 0;
        ncap  = 0;
        test_reset();
        test_digits_enter();
        test_back_to_back();
        test_overflow();
        test_stall_drop();
        test_held_key();
        test_idle_clear();
        test_reset_mid_cmd();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
